// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FQ_DEPTH_DEF = 4;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_PEND = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of {pc,instr} pairs between fetch and decode, with flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH_DEF,
  parameter int AW    = 2
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  fq_entry_t wr_data,
  output fq_entry_t rd_data,
  output logic      full,
  output logic      empty,
  output logic [AW:0] count
);

  fq_entry_t      mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  // Flush wins over push/pop; a pop in the flush cycle is simply absorbed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, redirect FSM, push gating into fetch_queue.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = FQ_DEPTH_DEF,
  parameter int          FQ_AW    = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [31:0]      pc,
  input  logic [31:0]      instr,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [31:0]      dec_instr,
  output logic [31:0]      dec_pc,
  output logic [FQ_AW:0]   fq_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_fetched
`endif
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_next;
  logic [31:0]  pend_pc, pend_pc_next;
  logic         push;
  logic         pop;
  logic         flush;
  logic         fq_full;
  logic         fq_empty;
  fq_entry_t    wr_entry;
  fq_entry_t    head;

  assign pop       = dec_valid & dec_ready;
  assign dec_valid = ~fq_empty;
  assign dec_pc    = head.pc;
  assign dec_instr = head.instr;
  assign wr_entry  = '{pc: pc, instr: instr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RUN;
      pc      <= RESET_PC;
      pend_pc <= RESET_PC;
    end else begin
      state   <= state_next;
      pc      <= pc_next;
      pend_pc <= pend_pc_next;
    end
  end

  // While a miss is outstanding the cache still owns pc, so a redirect is parked in pend_pc.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pend_pc_next = pend_pc;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      S_RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (!stall) begin
            pc_next = word_align(redirect_pc);
          end else begin
            pend_pc_next = word_align(redirect_pc);
            state_next   = S_PEND;
          end
        end else if (!stall && (!fq_full || pop)) begin
          push    = 1'b1;
          pc_next = pc + PC_INC;
        end
      end
      S_PEND: begin
        if (redirect_valid) begin
          flush        = 1'b1;
          pend_pc_next = word_align(redirect_pc);
        end
        if (!stall) begin
          pc_next    = redirect_valid ? word_align(redirect_pc) : pend_pc;
          state_next = S_RUN;
        end
      end
      default: state_next = S_RUN;
    endcase
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .AW    (FQ_AW)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fq_full),
    .empty   (fq_empty),
    .count   (fq_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cyc <= '0;
      perf_fetched   <= '0;
    end else begin
      if (stall) begin
        perf_stall_cyc <= sat_inc(perf_stall_cyc);
      end
      if (push) begin
        perf_fetched <= sat_inc(perf_fetched);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; the cache model returns instr = pc + 0x1000_0000.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [2:0]  fq_count;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [31:0] perf_fetched;
`endif

  int n_checks;
  int n_fail;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .FQ_DEPTH (4),
    .FQ_AW    (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pc             (pc),
    .instr          (instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .fq_count       (fq_count)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_fetched   (perf_fetched)
`endif
  );

  assign instr = pc + 32'h1000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    dec_ready      = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dec_valid: got %b expected 0", dec_valid); end
    n_checks++; if (dec_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dec_pc: got %h expected 0", dec_pc); end
    n_checks++; if (dec_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dec_instr: got %h expected 0", dec_instr); end
    n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_fq_count: got %0d expected 0", fq_count); end
    reset_n = 1'b1;
  endtask

  task automatic test_hits();
    logic [31:0] exp_pc;
    do_reset();
    dec_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_pc = 32'(i * 4);
      n_checks++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL hit_pc[%0d]: got %h expected %h", i, pc, exp_pc); end
      tick();
      n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL hit_dec_valid[%0d]: got %b expected 1", i, dec_valid); end
      n_checks++; if (dec_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL hit_dec_pc[%0d]: got %h expected %h", i, dec_pc, exp_pc); end
      n_checks++; if (dec_instr !== exp_pc + 32'h1000_0000) begin n_fail++; $display("[TB] FAIL hit_dec_instr[%0d]: got %h expected %h", i, dec_instr, exp_pc + 32'h1000_0000); end
      n_checks++; if (fq_count !== 3'd1) begin n_fail++; $display("[TB] FAIL hit_fq_count[%0d]: got %0d expected 1", i, fq_count); end
    end
  endtask

  task automatic test_full_queue();
    do_reset();
    repeat (4) tick();
    n_checks++; if (fq_count !== 3'd4) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected 4", fq_count); end
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("[TB] FAIL full_pc: got %h expected %h", pc, 32'h10); end
    repeat (2) tick();
    n_checks++; if (pc !== 32'h10) begin n_fail++; $display("[TB] FAIL full_pc_held: got %h expected %h", pc, 32'h10); end
    n_checks++; if (fq_count !== 3'd4) begin n_fail++; $display("[TB] FAIL full_count_held: got %0d expected 4", fq_count); end
    n_checks++; if (dec_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL full_head: got %h expected 0", dec_pc); end
    dec_ready = 1'b1;
    tick();
    n_checks++; if (pc !== 32'h14) begin n_fail++; $display("[TB] FAIL full_resume_pc: got %h expected %h", pc, 32'h14); end
    n_checks++; if (fq_count !== 3'd4) begin n_fail++; $display("[TB] FAIL full_pushpop_count: got %0d expected 4", fq_count); end
    n_checks++; if (dec_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL full_pushpop_head: got %h expected %h", dec_pc, 32'h4); end
  endtask

  // Stall at 0x40, then redirect with no stall, then parked redirects during a stall.
  task automatic test_stall_and_redirect();
    do_reset();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    stall          = 1'b1;
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("[TB] FAIL stall_setup_pc: got %h expected %h", pc, 32'h40); end
    repeat (5) tick();
    n_checks++; if (pc !== 32'h40) begin n_fail++; $display("[TB] FAIL stall_pc: got %h expected %h", pc, 32'h40); end
    n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("[TB] FAIL stall_count: got %0d expected 0", fq_count); end
    stall = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h44) begin n_fail++; $display("[TB] FAIL unstall_pc: got %h expected %h", pc, 32'h44); end
    n_checks++; if (dec_pc !== 32'h40 || dec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL unstall_dec_pc: got %h/%b expected %h/1", dec_pc, dec_valid, 32'h40); end
    n_checks++; if (dec_instr !== 32'h1000_0040) begin n_fail++; $display("[TB] FAIL unstall_dec_instr: got %h expected %h", dec_instr, 32'h1000_0040); end

    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'h100) begin n_fail++; $display("[TB] FAIL redir_pc: got %h expected %h", pc, 32'h100); end
    n_checks++; if (fq_count !== 3'd0 || dec_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_flush: got count %0d valid %b expected 0/0", fq_count, dec_valid); end
    tick();
    n_checks++; if (dec_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL redir_first: got %h expected %h", dec_pc, 32'h100); end
    n_checks++; if (pc !== 32'h104) begin n_fail++; $display("[TB] FAIL redir_next_pc: got %h expected %h", pc, 32'h104); end

    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'h104) begin n_fail++; $display("[TB] FAIL pend_pc_held: got %h expected %h", pc, 32'h104); end
    n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("[TB] FAIL pend_flush: got %0d expected 0", fq_count); end
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h104) begin n_fail++; $display("[TB] FAIL pend_pc_held2: got %h expected %h", pc, 32'h104); end
    stall = 1'b0;
    tick();
    n_checks++; if (pc !== 32'h300) begin n_fail++; $display("[TB] FAIL pend_release_pc: got %h expected %h", pc, 32'h300); end
    n_checks++; if (fq_count !== 3'd0) begin n_fail++; $display("[TB] FAIL pend_release_nopush: got %0d expected 0", fq_count); end
    tick();
    n_checks++; if (pc !== 32'h304 || dec_pc !== 32'h300) begin n_fail++; $display("[TB] FAIL pend_resume: got pc %h head %h expected %h/%h", pc, dec_pc, 32'h304, 32'h300); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    dec_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_align: got %h expected %h", pc, 32'hFFFF_FFFC); end
    tick();
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL wrap_pc: got %h expected 0", pc); end
    n_checks++; if (dec_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_dec_pc: got %h expected %h", dec_pc, 32'hFFFF_FFFC); end
    n_checks++; if (dec_instr !== 32'h0FFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_dec_instr: got %h expected %h", dec_instr, 32'h0FFF_FFFC); end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    do_reset();
    dec_ready = 1'b1;
    stall     = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    repeat (5) tick();
    n_checks++; if (perf_stall_cyc !== 32'd3) begin n_fail++; $display("[TB] FAIL perf_stall: got %0d expected 3", perf_stall_cyc); end
    n_checks++; if (perf_fetched !== 32'd5) begin n_fail++; $display("[TB] FAIL perf_fetched: got %0d expected 5", perf_fetched); end
    n_checks++; if (pc !== 32'h14) begin n_fail++; $display("[TB] FAIL perf_pc: got %h expected %h", pc, 32'h14); end
  endtask
`endif

  task automatic test_reset_mid_run();
    do_reset();
    repeat (3) tick();
    stall = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_pc: got %h expected 0", pc); end
    n_checks++; if (dec_valid !== 1'b0 || fq_count !== 3'd0) begin n_fail++; $display("[TB] FAIL midrst_queue: got valid %b count %0d expected 0/0", dec_valid, fq_count); end
    n_checks++; if (dec_pc !== 32'h0 || dec_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_head: got %h/%h expected 0/0", dec_pc, dec_instr); end
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_stall_cyc !== 32'd0 || perf_fetched !== 32'd0) begin n_fail++; $display("[TB] FAIL midrst_perf: got %0d/%0d expected 0/0", perf_stall_cyc, perf_fetched); end
`endif
    tick();
    stall   = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_hits();
    test_full_queue();
    test_stall_and_redirect();
    test_pc_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
